// File: rtl/firmware_config_tx.sv
// Config-bus transmitter: buffers host firmware-table writes in a small FIFO and
// serialises each one as a header byte, a data byte and a one-cycle idle gap.
module firmware_config_tx #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MAX_CHAINS = 4,
  parameter logic [7:0]  IDLE_ID    = 8'hFF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [7:0]                    req_target,
  input  logic [2:0]                    req_field,
  input  logic [$clog2(MAX_CHAINS)-1:0] req_chain,
  input  logic [7:0]                    req_value,
  output logic [7:0]                    configId,
  output logic [7:0]                    configData,
  output logic                          busy,
  output logic                          err_pulse,
  output logic [15:0]                   tx_count
);

  localparam int unsigned CW = $clog2(MAX_CHAINS);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned NW = AW + 1;
  localparam logic [NW-1:0] CNT_FULL = NW'(FIFO_DEPTH);
  localparam logic [NW-1:0] CNT_ZERO = NW'(1'b0);
  localparam logic [NW-1:0] CNT_ONE  = NW'(1'b1);
  localparam logic [AW-1:0] PTR_ZERO = AW'(1'b0);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);

  typedef struct packed {
    logic [7:0]    target;
    logic [2:0]    field;
    logic [CW-1:0] chain;
    logic [7:0]    value;
  } req_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  // Header byte: top bit clear, table field, chain index zero-extended to a nibble.
  function automatic logic [7:0] hdr_byte(input req_t r);
    return {1'b0, r.field, 4'(r.chain)};
  endfunction

  req_t          mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [NW-1:0] count_r;
  state_t        state_r;
  state_t        state_nx_s;
  req_t          head_s;
  logic [7:0]    frame_tgt_r;
  logic [7:0]    frame_val_r;
  logic [7:0]    cfg_id_r;
  logic [7:0]    cfg_data_r;
  logic          err_r;
  logic [15:0]   tx_r;
  logic          accept_s;
  logic          bad_s;
  logic          push_s;
  logic          pop_s;

  assign req_ready = (count_r < CNT_FULL);
  assign accept_s  = req_valid && req_ready;
  assign bad_s     = (req_target == IDLE_ID) || (req_field > 3'd5);
  assign push_s    = accept_s && !bad_s;
  assign head_s    = mem_r[rd_ptr_r];
  assign busy      = (state_r != ST_IDLE) || (count_r != CNT_ZERO);

  assign configId   = cfg_id_r;
  assign configData = cfg_data_r;
  assign err_pulse  = err_r;
  assign tx_count   = tx_r;

  // Request storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {req_target, req_field, req_chain, req_value};
    end
  end

  // FIFO pointers and occupancy; a push and pop on the same edge cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      if (push_s && !pop_s) begin
        count_r <= count_r + CNT_ONE;
      end else if (pop_s && !push_s) begin
        count_r <= count_r - CNT_ONE;
      end else begin
        count_r <= count_r;
      end
    end
  end

  // Frame sequencer next state: a new frame may start from IDLE or straight out of GAP.
  always_comb begin
    state_nx_s = state_r;
    pop_s      = 1'b0;
    case (state_r)
      ST_IDLE, ST_GAP: begin
        if (count_r != CNT_ZERO) begin
          pop_s      = 1'b1;
          state_nx_s = ST_HDR;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_HDR:  state_nx_s = ST_DATA;
      ST_DATA: state_nx_s = ST_GAP;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Frame sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Bus outputs are computed from the next state so each byte appears right after its edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_tgt_r <= 8'h00;
      frame_val_r <= 8'h00;
      cfg_id_r    <= IDLE_ID;
      cfg_data_r  <= 8'h00;
      err_r       <= 1'b0;
      tx_r        <= 16'h0000;
    end else begin
      err_r <= accept_s && bad_s;
      if (pop_s) begin
        frame_tgt_r <= head_s.target;
        frame_val_r <= head_s.value;
      end
      case (state_nx_s)
        ST_HDR: begin
          cfg_id_r   <= head_s.target;
          cfg_data_r <= hdr_byte(head_s);
        end
        ST_DATA: begin
          cfg_id_r   <= frame_tgt_r;
          cfg_data_r <= frame_val_r;
        end
        default: begin
          cfg_id_r   <= IDLE_ID;
          cfg_data_r <= 8'h00;
        end
      endcase
      if (state_r == ST_DATA) begin
        tx_r <= tx_r + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_firmware_config_tx.sv
// Bench for firmware_config_tx: directed vector table, ordered bursts, random
// traffic against a frame-schedule reference model, and reset mid-frame.
module tb_firmware_config_tx;

  localparam int DEPTH = 4;
  localparam int MAXC  = 4;
  localparam int CW    = $clog2(MAXC);
  localparam logic [7:0] IDLE = 8'hFF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          req_valid;
  logic          req_ready;
  logic [7:0]    req_target;
  logic [2:0]    req_field;
  logic [CW-1:0] req_chain;
  logic [7:0]    req_value;
  logic [7:0]    configId;
  logic [7:0]    configData;
  logic          busy;
  logic          err_pulse;
  logic [15:0]   tx_count;

  always #5 clk = ~clk;

  firmware_config_tx #(
    .FIFO_DEPTH(DEPTH),
    .MAX_CHAINS(MAXC),
    .IDLE_ID   (IDLE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_target(req_target),
    .req_field (req_field),
    .req_chain (req_chain),
    .req_value (req_value),
    .configId  (configId),
    .configData(configData),
    .busy      (busy),
    .err_pulse (err_pulse),
    .tx_count  (tx_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a queue of accepted requests plus the edge on which the
  // current frame started; bus bytes follow from the distance to that edge.
  typedef struct {
    logic [7:0]    t;
    logic [2:0]    f;
    logic [CW-1:0] c;
    logic [7:0]    v;
  } rq_t;

  rq_t         pend[$];
  rq_t         cur;
  int          edge_n = -1;
  int          cur_start = -100;
  logic [15:0] exp_tx = 16'd0;
  logic        exp_err = 1'b0;

  typedef struct {
    logic          v;
    logic [7:0]    t;
    logic [2:0]    f;
    logic [CW-1:0] c;
    logic [7:0]    val;
    logic [7:0]    eid;
    logic [7:0]    edat;
    logic          eerr;
    logic [15:0]   etx;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    cur_start = -100;
    exp_tx    = 16'd0;
    exp_err   = 1'b0;
  endtask

  // One clock edge: check ready before it, advance the model, check outputs #1 after it.
  task automatic tick(output bit acc_o, output bit full_pop_o);
    bit          acc;
    bit          bad;
    bit          pop;
    int          d;
    rq_t         r;
    logic [7:0]  eid;
    logic [7:0]  edat;
    chk("req_ready", {31'd0, req_ready}, (pend.size() < DEPTH) ? 32'd1 : 32'd0);
    acc = req_valid && (pend.size() < DEPTH);
    bad = (req_target == IDLE) || (req_field > 3'd5);
    r   = '{req_target, req_field, req_chain, req_value};
    @(posedge clk);
    edge_n++;
    pop        = (pend.size() != 0) && (edge_n >= cur_start + 3);
    full_pop_o = pop && req_valid && (pend.size() == DEPTH);
    if (pop) begin
      cur       = pend.pop_front();
      cur_start = edge_n;
    end
    if (acc && !bad) pend.push_back(r);
    exp_err = acc && bad;
    d = edge_n - cur_start;
    if (d == 2) exp_tx = exp_tx + 16'd1;
    if (d == 0) begin
      eid  = cur.t;
      edat = {1'b0, cur.f, 4'(cur.c)};
    end else if (d == 1) begin
      eid  = cur.t;
      edat = cur.v;
    end else begin
      eid  = IDLE;
      edat = 8'h00;
    end
    #1;
    chk("configId", {24'd0, configId}, {24'd0, eid});
    chk("configData", {24'd0, configData}, {24'd0, edat});
    chk("err_pulse", {31'd0, err_pulse}, {31'd0, exp_err});
    chk("tx_count", {16'd0, tx_count}, {16'd0, exp_tx});
    chk("busy", {31'd0, busy}, ((pend.size() != 0) || (d <= 2)) ? 32'd1 : 32'd0);
    acc_o = acc;
  endtask

  // Holds req_valid high through n distinct requests and checks order, spacing and count.
  task automatic burst(input int n, input int base, output bit full_pop_seen, output int ready_low);
    int          idx;
    int          cyc;
    bit          a;
    bit          fp;
    logic [15:0] tx_start;
    logic [15:0] got[$];
    int          hdr_edges[$];
    idx = 0;
    cyc = 0;
    ready_low = 0;
    full_pop_seen = 1'b0;
    tx_start = exp_tx;
    while (got.size() < 2 * n && cyc < 200) begin
      if (idx < n) begin
        req_valid  = 1'b1;
        req_target = 8'(base + idx);
        req_field  = 3'(idx % 6);
        req_chain  = CW'(idx % MAXC);
        req_value  = 8'(8'hA0 + idx);
      end else begin
        req_valid = 1'b0;
      end
      if (!req_ready) ready_low++;
      tick(a, fp);
      if (fp) full_pop_seen = 1'b1;
      if (a && idx < n) idx++;
      if (configId != IDLE) begin
        if (got.size() % 2 == 0) hdr_edges.push_back(edge_n);
        got.push_back({configId, configData});
      end
      cyc++;
    end
    req_valid = 1'b0;
    tick(a, fp);
    chk("burst_bytes", got.size(), 2 * n);
    for (int i = 0; i < n && 2 * i + 1 < got.size(); i++) begin
      chk($sformatf("burst_hdr%0d", i), {16'd0, got[2 * i]},
          {16'd0, 8'(base + i), 1'b0, 3'(i % 6), 4'(i % MAXC)});
      chk($sformatf("burst_dat%0d", i), {16'd0, got[2 * i + 1]},
          {16'd0, 8'(base + i), 8'(8'hA0 + i)});
    end
    for (int i = 1; i < hdr_edges.size(); i++) begin
      chk("burst_spacing", hdr_edges[i] - hdr_edges[i - 1], 3);
    end
    chk("burst_tx", {16'd0, tx_count}, {16'd0, 16'(tx_start + 16'(n))});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit a;
    bit fp;
    bit fp6;
    bit fp8;
    int rl6;
    int rl8;
    bit found;

    vecs[0] = '{1'b1, 8'hFF, 3'd0, 2'd0, 8'h00, 8'hFF, 8'h00, 1'b1, 16'd0};
    vecs[1] = '{1'b1, 8'h10, 3'd6, 2'd1, 8'hAA, 8'hFF, 8'h00, 1'b1, 16'd0};
    vecs[2] = '{1'b0, 8'h10, 3'd1, 2'd1, 8'hAA, 8'hFF, 8'h00, 1'b0, 16'd0};
    vecs[3] = '{1'b1, 8'h03, 3'd1, 2'd2, 8'h05, 8'hFF, 8'h00, 1'b0, 16'd0};
    vecs[4] = '{1'b0, 8'h00, 3'd0, 2'd0, 8'h00, 8'h03, 8'h12, 1'b0, 16'd0};
    vecs[5] = '{1'b0, 8'h00, 3'd0, 2'd0, 8'h00, 8'h03, 8'h05, 1'b0, 16'd0};
    vecs[6] = '{1'b0, 8'h00, 3'd0, 2'd0, 8'h00, 8'hFF, 8'h00, 1'b0, 16'd1};
    vecs[7] = '{1'b0, 8'h00, 3'd0, 2'd0, 8'h00, 8'hFF, 8'h00, 1'b0, 16'd1};

    req_valid  = 1'b0;
    req_target = 8'h00;
    req_field  = 3'd0;
    req_chain  = '0;
    req_value  = 8'h00;
    model_reset();

    #2 rst_n = 1'b0;
    #1;
    chk("rst_configId", {24'd0, configId}, 32'h0000_00FF);
    chk("rst_configData", {24'd0, configData}, 32'd0);
    chk("rst_err", {31'd0, err_pulse}, 32'd0);
    chk("rst_tx", {16'd0, tx_count}, 32'd0);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      req_valid  = vecs[i].v;
      req_target = vecs[i].t;
      req_field  = vecs[i].f;
      req_chain  = vecs[i].c;
      req_value  = vecs[i].val;
      tick(a, fp);
      chk($sformatf("vec%0d_id", i), {24'd0, configId}, {24'd0, vecs[i].eid});
      chk($sformatf("vec%0d_data", i), {24'd0, configData}, {24'd0, vecs[i].edat});
      chk($sformatf("vec%0d_err", i), {31'd0, err_pulse}, {31'd0, vecs[i].eerr});
      chk($sformatf("vec%0d_tx", i), {16'd0, tx_count}, {16'd0, vecs[i].etx});
    end
    req_valid = 1'b0;

    burst(6, 8'h20, fp6, rl6);
    chk("burst6_ready_dropped", (rl6 > 0) ? 32'd1 : 32'd0, 32'd1);
    burst(8, 8'h40, fp8, rl8);
    chk("burst8_full_with_pop", {31'd0, fp8}, 32'd1);

    for (int i = 0; i < 1500; i++) begin
      req_valid  = ($urandom_range(0, 9) < 6);
      req_target = ($urandom_range(0, 9) == 0) ? IDLE : 8'($urandom_range(0, 254));
      req_field  = 3'($urandom_range(0, 7));
      req_chain  = CW'($urandom_range(0, MAXC - 1));
      req_value  = 8'($urandom);
      tick(a, fp);
    end
    req_valid = 1'b0;
    for (int i = 0; i < 30; i++) tick(a, fp);

    req_valid  = 1'b1;
    req_field  = 3'd2;
    req_chain  = CW'(1);
    req_target = 8'h51;
    req_value  = 8'h61;
    tick(a, fp);
    req_target = 8'h52;
    req_value  = 8'h62;
    tick(a, fp);
    req_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (edge_n - cur_start == 1) found = 1'b1;
      else tick(a, fp);
    end
    chk("reached_data", {31'd0, found}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_configId", {24'd0, configId}, 32'h0000_00FF);
    chk("midrst_configData", {24'd0, configData}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_tx", {16'd0, tx_count}, 32'd0);
    chk("midrst_ready", {31'd0, req_ready}, 32'd1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) tick(a, fp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/firmware_config_tx.md
FIRMWARE_CONFIG_TX -- requirements
Module: firmware_config_tx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, request buffer depth (power of 2, >=2).
REQ-002 SHALL have parameter MAX_CHAINS, default 4, number of chains addressed (2..16).
REQ-003 SHALL have parameter IDLE_ID, default 8'hFF, configId value driven when no frame is on the bus.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid  input  1  host firmware-write request valid.
REQ-007 SHALL have port req_ready  output  1  request buffer can accept.
REQ-008 SHALL have port req_target  input  8  PERSONAL_CONFIG_ID of destination block.
REQ-009 SHALL have port req_field  input  3  firmware table: 0 op, 1 addr_rd, 2 cond, 3 cache, 4 cache_addr, 5 cache_cond.
REQ-010 SHALL have port req_chain  input  $clog2(MAX_CHAINS)  chain index of entry.
REQ-011 SHALL have port req_value  input  8  value to write.
REQ-012 SHALL have port configId  output  8  config bus destination id.
REQ-013 SHALL have port configData  output  8  config bus payload byte.
REQ-014 SHALL have port busy  output  1  FIFO non-empty or frame in progress.
REQ-015 SHALL have port err_pulse  output  1  one-cycle pulse on rejected request.
REQ-016 SHALL have port tx_count  output  16  completed frames, wraps 16'hFFFF->0.

Function
REQ-017 SHALL accept a request on a rising edge where req_valid && req_ready.
REQ-018 SHALL drive req_ready = (FIFO occupancy < FIFO_DEPTH), with no same-cycle pass-through when full, even if a pop occurs that edge.
REQ-019 SHALL reject an accepted request with req_target==IDLE_ID or req_field>5: not enqueued; err_pulse high for exactly the following cycle.
REQ-020 SHALL implement FSM states IDLE, HDR, DATA, GAP; configId/configData/err_pulse/tx_count registered.
REQ-021 IDLE: if FIFO non-empty at edge, pop head into frame register, go HDR; else stay; outputs configId=IDLE_ID, configData=0.
REQ-022 HDR (1 cycle): configId=target, configData={1'b0, field, chain zero-extended to 4 bits}; next DATA.
REQ-023 DATA (1 cycle): configId=target, configData=value; next GAP; tx_count increments on the HDR->DATA... exit of DATA edge.
REQ-024 GAP (1 cycle): configId=IDLE_ID, configData=0; if FIFO non-empty pop and go HDR, else IDLE.
REQ-025 Latency: request accepted at edge k with FIFO empty and FSM IDLE -> header visible after edge k+1, data after k+2, gap after k+3.
REQ-026 Sustained throughput SHALL be one frame per 3 cycles; frames emitted strictly in acceptance order.
REQ-027 Simultaneous push and pop SHALL keep occupancy unchanged; read/write pointers wrap modulo FIFO_DEPTH.
REQ-028 busy SHALL be combinational: (state!=IDLE) || (occupancy!=0).
REQ-029 Request inputs SHALL be ignored when req_valid low or req_ready low.

Reset
REQ-030 rst_n low SHALL immediately force state IDLE, FIFO empty, configId=IDLE_ID, configData=0, err_pulse=0, tx_count=0, req_ready=1, busy=0.
REQ-031 Reset mid-frame SHALL abandon the frame (no DATA byte emitted, tx_count not incremented); operation resumes on first edge after rst_n high.

Verification
REQ-032 Single write: target 8'h03, field 1, chain 2, value 8'h05 into idle block -> after k+1 configId=03/configData=8'h12, after k+2 03/05, after k+3 FF/00, tx_count=1.
REQ-033 Back-to-back: 6 requests with req_valid held high, FIFO_DEPTH 4 -> req_ready drops after 4th push beyond pops, all 6 frames in order, 3-cycle spacing, tx_count=6.
REQ-034 Reject: target 8'hFF, then field 6 -> two err_pulse cycles, no frame, configId stays FF, tx_count=0.
REQ-035 Full-with-pop: FIFO full while FSM pops in GAP, req_valid high -> no acceptance that edge; accepted next edge; no loss or duplication.
REQ-036 Reset during DATA -> outputs FF/00 asynchronously, busy=0, tx_count=0; queued requests discarded.
